// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared select codes, source enum and entry type for the writeback arbiter
package wb_pkg;

    localparam int RD_W     = 5;
    localparam int XLEN_DEF = 32;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_AU   = 3'b001;
    localparam logic [2:0] SEL_MUL  = 3'b010;
    localparam logic [2:0] SEL_LSU  = 3'b100;

    // Source index doubles as the bit position of its one-hot select code.
    typedef enum logic [1:0] {
        SRC_AU  = 2'd0,
        SRC_MUL = 2'd1,
        SRC_LSU = 2'd2
    } src_e;

    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;

    // Round-robin successor: AU -> MUL -> LSU -> AU.
    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_AU:  return SRC_MUL;
            SRC_MUL: return SRC_LSU;
            default: return SRC_AU;
        endcase
    endfunction

    function automatic logic [2:0] sel_of(input src_e s);
        case (s)
            SRC_AU:  return SEL_AU;
            SRC_MUL: return SEL_MUL;
            default: return SEL_LSU;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source result FIFO with count-based ready
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   ready,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    // Ready comes only from the registered count, so a full FIFO stays
    // closed even in a cycle where its head is being popped.
    assign ready  = (r_count < (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && ready && !flush;
    assign w_pop  = pop && !empty && !flush;
    assign dout   = r_mem[r_rd_ptr];

    // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter over AU/MUL/LSU result FIFOs
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            au_valid,
    input  logic            mul_valid,
    input  logic            lsu_valid,
    output logic            au_ready,
    output logic            mul_ready,
    output logic            lsu_ready,
    input  logic [4:0]      au_rd,
    input  logic [4:0]      mul_rd,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] au_data,
    input  logic [XLEN-1:0] mul_data,
    input  logic [XLEN-1:0] lsu_data,
    output logic [XLEN-1:0] wb_au_result,
    output logic [XLEN-1:0] wb_mul_result,
    output logic [XLEN-1:0] wb_lsu_result,
    output logic [2:0]      wb_select,
    output logic [4:0]      wb_rd,
    output logic            wb_we
);

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } entry_t;

    logic [2:0]      w_valid;
    logic [2:0]      w_ready;
    logic [2:0]      w_empty;
    logic [2:0]      w_pop;
    entry_t          w_din  [3];
    entry_t          w_head [3];
    entry_t          w_head_sel;
    src_e            w_c0, w_c1, w_c2, w_gnt;
    logic            w_gnt_valid;

    src_e            r_last;
    logic [2:0]      r_sel;
    logic [4:0]      r_rd;
    logic            r_we;
    logic [XLEN-1:0] r_au_result;
    logic [XLEN-1:0] r_mul_result;
    logic [XLEN-1:0] r_lsu_result;

    assign w_valid        = {lsu_valid, mul_valid, au_valid};
    assign w_din[SRC_AU]  = '{rd: au_rd,  data: au_data};
    assign w_din[SRC_MUL] = '{rd: mul_rd, data: mul_data};
    assign w_din[SRC_LSU] = '{rd: lsu_rd, data: lsu_data};

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        wb_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (w_valid[g]),
            .din   (w_din[g]),
            .pop   (w_pop[g]),
            .dout  (w_head[g]),
            .ready (w_ready[g]),
            .empty (w_empty[g])
        );
    end

    assign au_ready  = w_ready[SRC_AU];
    assign mul_ready = w_ready[SRC_MUL];
    assign lsu_ready = w_ready[SRC_LSU];

    // Round-robin pick: search the non-empty FIFOs starting after the last grant.
    always_comb begin
        w_c0        = next_src(r_last);
        w_c1        = next_src(w_c0);
        w_c2        = next_src(w_c1);
        w_gnt       = w_c0;
        w_gnt_valid = 1'b1;
        if (!w_empty[w_c0])      w_gnt = w_c0;
        else if (!w_empty[w_c1]) w_gnt = w_c1;
        else if (!w_empty[w_c2]) w_gnt = w_c2;
        else                     w_gnt_valid = 1'b0;
        w_pop      = w_gnt_valid ? sel_of(w_gnt) : SEL_NONE;
        w_head_sel = w_head[w_gnt];
    end

    // Writeback output register and grant pointer; only the granted result lane updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last       <= SRC_LSU;
            r_sel        <= SEL_NONE;
            r_rd         <= '0;
            r_we         <= 1'b0;
            r_au_result  <= '0;
            r_mul_result <= '0;
            r_lsu_result <= '0;
        end else if (flush) begin
            r_last <= SRC_LSU;
            r_sel  <= SEL_NONE;
            r_we   <= 1'b0;
        end else if (w_gnt_valid) begin
            r_last <= w_gnt;
            r_sel  <= sel_of(w_gnt);
            r_rd   <= w_head_sel.rd;
            r_we   <= (w_head_sel.rd != '0);
            case (w_gnt)
                SRC_AU:  r_au_result  <= w_head_sel.data;
                SRC_MUL: r_mul_result <= w_head_sel.data;
                default: r_lsu_result <= w_head_sel.data;
            endcase
        end else begin
            r_sel <= SEL_NONE;
            r_we  <= 1'b0;
        end
    end

    assign wb_select     = r_sel;
    assign wb_rd         = r_rd;
    assign wb_we         = r_we;
    assign wb_au_result  = r_au_result;
    assign wb_mul_result = r_mul_result;
    assign wb_lsu_result = r_lsu_result;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        au_valid = 1'b0, mul_valid = 1'b0, lsu_valid = 1'b0;
    logic        au_ready, mul_ready, lsu_ready;
    logic [4:0]  au_rd = '0, mul_rd = '0, lsu_rd = '0;
    logic [31:0] au_data = '0, mul_data = '0, lsu_data = '0;
    logic [31:0] wb_au_result, wb_mul_result, wb_lsu_result;
    logic [2:0]  wb_select;
    logic [4:0]  wb_rd;
    logic        wb_we;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .au_valid(au_valid), .mul_valid(mul_valid), .lsu_valid(lsu_valid),
        .au_ready(au_ready), .mul_ready(mul_ready), .lsu_ready(lsu_ready),
        .au_rd(au_rd), .mul_rd(mul_rd), .lsu_rd(lsu_rd),
        .au_data(au_data), .mul_data(mul_data), .lsu_data(lsu_data),
        .wb_au_result(wb_au_result), .wb_mul_result(wb_mul_result), .wb_lsu_result(wb_lsu_result),
        .wb_select(wb_select), .wb_rd(wb_rd), .wb_we(wb_we)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        au_valid = 0; mul_valid = 0; lsu_valid = 0; flush = 0;
    endtask

    task automatic reset_dut;
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 0;
        #3;
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", wb_we); end
        n_checks++; if (wb_select !== 3'b000) begin n_fail++; $display("FAIL reset_sel got %b want 000", wb_select); end
        n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", wb_rd); end
        n_checks++; if ({wb_au_result, wb_mul_result, wb_lsu_result} !== 96'd0) begin n_fail++; $display("FAIL reset_results got %h %h %h want 0", wb_au_result, wb_mul_result, wb_lsu_result); end
        tick();
        rst_n = 1;
        tick();
        n_checks++; if ({au_ready, mul_ready, lsu_ready} !== 3'b111) begin n_fail++; $display("FAIL reset_ready got %b want 111", {au_ready, mul_ready, lsu_ready}); end
    endtask

    task automatic test_single_au;
        reset_dut();
        au_valid = 1; au_rd = 5; au_data = 32'h1234;
        tick();
        au_valid = 0;
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL single_early_we got %0b want 0", wb_we); end
        tick();
        n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL single_we got %0b want 1", wb_we); end
        n_checks++; if (wb_select !== SEL_AU) begin n_fail++; $display("FAIL single_sel got %b want 001", wb_select); end
        n_checks++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL single_rd got %0d want 5", wb_rd); end
        n_checks++; if (wb_au_result !== 32'h1234) begin n_fail++; $display("FAIL single_data got %h want 1234", wb_au_result); end
        tick();
        n_checks++; if (wb_select !== SEL_NONE || wb_we !== 1'b0) begin n_fail++; $display("FAIL single_idle got sel=%b we=%0b want 000/0", wb_select, wb_we); end
        n_checks++; if (wb_rd !== 5'd5 || wb_au_result !== 32'h1234) begin n_fail++; $display("FAIL single_hold got rd=%0d data=%h want 5/1234", wb_rd, wb_au_result); end
    endtask

    task automatic test_three_sources;
        logic [2:0]  exp_sel [3];
        logic [31:0] got_data;
        exp_sel[0] = SEL_AU; exp_sel[1] = SEL_MUL; exp_sel[2] = SEL_LSU;
        reset_dut();
        au_valid = 1;  au_rd = 1;  au_data = 32'hA0;
        mul_valid = 1; mul_rd = 2; mul_data = 32'hB0;
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'hC0;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            got_data = (i == 0) ? wb_au_result : (i == 1) ? wb_mul_result : wb_lsu_result;
            n_checks++; if (wb_select !== exp_sel[i] || wb_rd !== 5'(i + 1) || wb_we !== 1'b1) begin n_fail++; $display("FAIL rr_order[%0d] got sel=%b rd=%0d we=%0b want sel=%b rd=%0d we=1", i, wb_select, wb_rd, wb_we, exp_sel[i], i + 1); end
            n_checks++; if (got_data !== 32'hA0 + 32'(i) * 32'h10) begin n_fail++; $display("FAIL rr_data[%0d] got %h want %h", i, got_data, 32'hA0 + 32'(i) * 32'h10); end
        end
        tick();
        n_checks++; if (wb_select !== SEL_NONE || wb_we !== 1'b0) begin n_fail++; $display("FAIL rr_idle got sel=%b we=%0b want 000/0", wb_select, wb_we); end
    endtask

    task automatic test_backpressure;
        int         idx;
        logic       acc;
        logic [4:0] got_rd [$];
        logic [31:0] got_dat [$];
        idx = 0;
        reset_dut();
        au_rd = 7; au_data = 32'h7; lsu_rd = 9; lsu_data = 32'h9;
        for (int cyc = 0; cyc < 30; cyc++) begin
            au_valid  = (cyc < 4);
            lsu_valid = (cyc < 4);
            mul_valid = (idx < 3);
            mul_rd    = 5'(11 + idx);
            mul_data  = 32'(256 + 11 + idx);
            acc = mul_valid && mul_ready;
            tick();
            if (acc) idx++;
            if (cyc == 1) begin
                n_checks++; if (mul_ready !== 1'b0) begin n_fail++; $display("FAIL bp_mul_full got ready=%0b want 0", mul_ready); end
            end
            if (wb_select === SEL_MUL) begin
                got_rd.push_back(wb_rd);
                got_dat.push_back(wb_mul_result);
            end
        end
        idle_inputs();
        n_checks++; if (idx != 3) begin n_fail++; $display("FAIL bp_accepted got %0d want 3", idx); end
        n_checks++; if (got_rd.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", got_rd.size()); end
        for (int i = 0; i < got_rd.size() && i < 3; i++) begin
            n_checks++; if (got_rd[i] !== 5'(11 + i) || got_dat[i] !== 32'(267 + i)) begin n_fail++; $display("FAIL bp_order[%0d] got rd=%0d data=%0d want rd=%0d data=%0d", i, got_rd[i], got_dat[i], 11 + i, 267 + i); end
        end
    endtask

    task automatic test_rd_zero;
        reset_dut();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD;
        tick();
        idle_inputs();
        tick();
        n_checks++; if (wb_select !== SEL_LSU) begin n_fail++; $display("FAIL rd0_sel got %b want 100", wb_select); end
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %0b want 0", wb_we); end
        n_checks++; if (wb_lsu_result !== 32'hDEAD) begin n_fail++; $display("FAIL rd0_data got %h want dead", wb_lsu_result); end
    endtask

    task automatic test_back_to_back;
        reset_dut();
        au_valid = 1;
        for (int k = 0; k < 6; k++) begin
            au_rd = 5'(20 + k); au_data = 32'(1000 + k);
            tick();
            if (k > 0) begin
                n_checks++; if (wb_select !== SEL_AU || wb_we !== 1'b1 || wb_rd !== 5'(19 + k) || wb_au_result !== 32'(999 + k)) begin n_fail++; $display("FAIL b2b[%0d] got sel=%b we=%0b rd=%0d data=%0d want 001/1/%0d/%0d", k, wb_select, wb_we, wb_rd, wb_au_result, 19 + k, 999 + k); end
            end
            n_checks++; if (au_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %0b want 1", k, au_ready); end
        end
        idle_inputs();
    endtask

    task automatic test_flush;
        logic bad;
        reset_dut();
        au_valid = 1; mul_valid = 1; lsu_valid = 1;
        au_rd = 4; mul_rd = 5; lsu_rd = 6;
        tick(); tick();
        flush = 1;
        tick();
        flush = 0;
        n_checks++; if ({au_ready, mul_ready, lsu_ready} !== 3'b111) begin n_fail++; $display("FAIL flush_ready got %b want 111", {au_ready, mul_ready, lsu_ready}); end
        n_checks++; if (wb_we !== 1'b0 || wb_select !== SEL_NONE) begin n_fail++; $display("FAIL flush_out got we=%0b sel=%b want 0/000", wb_we, wb_select); end
        idle_inputs();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wb_we !== 1'b0 || wb_select !== SEL_NONE) bad = 1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL flush_drained got a writeback want none"); end
        au_valid = 1; mul_valid = 1; lsu_valid = 1;
        tick();
        idle_inputs();
        tick();
        n_checks++; if (wb_select !== SEL_AU || wb_rd !== 5'd4) begin n_fail++; $display("FAIL flush_ptr got sel=%b rd=%0d want 001/4", wb_select, wb_rd); end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid;
        logic bad;
        reset_dut();
        au_valid = 1; mul_valid = 1; lsu_valid = 1;
        au_rd = 1; mul_rd = 2; lsu_rd = 3;
        au_data = 32'h11; mul_data = 32'h22; lsu_data = 32'h33;
        tick(); tick();
        #2;
        rst_n = 0;
        #1;
        n_checks++; if (wb_we !== 1'b0 || wb_select !== SEL_NONE || wb_rd !== 5'd0) begin n_fail++; $display("FAIL midrst_out got we=%0b sel=%b rd=%0d want 0/000/0", wb_we, wb_select, wb_rd); end
        n_checks++; if ({wb_au_result, wb_mul_result, wb_lsu_result} !== 96'd0) begin n_fail++; $display("FAIL midrst_results got %h %h %h want 0", wb_au_result, wb_mul_result, wb_lsu_result); end
        idle_inputs();
        tick();
        rst_n = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wb_we !== 1'b0 || wb_select !== SEL_NONE) bad = 1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL midrst_stale got a writeback want none"); end
        n_checks++; if ({au_ready, mul_ready, lsu_ready} !== 3'b111) begin n_fail++; $display("FAIL midrst_ready got %b want 111", {au_ready, mul_ready, lsu_ready}); end
    endtask

    initial begin
        test_reset();
        test_single_au();
        test_three_sources();
        test_backpressure();
        test_rd_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
